// File: rtl/seven_segment_scan_decoder.sv
// -----------------------------------------------------------------------------
// seven_segment_scan_decoder
//
// Receive-side monitor for a 4-digit multiplexed seven-segment display.
// Samples the active-low digit strobes and segment lines. Each stable
// strobe/segment pair is decoded back to a 4-bit code and stored per digit.
// The block reports completed frames, illegal segment patterns and a stalled
// scan.
//
// Parameters:
//   STABLE_CYCLES  : identical consecutive samples needed before commit (1..255)
//   TIMEOUT_CYCLES : cycles without a commit before scan_timeout (>= 8)
//
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous, active-high reset
//   digit_in     in   [3:0] digit strobes, active-low, bit k selects digit k
//   display_in   in   [6:0] segments, active-low, {a,b,c,d,e,f,g}
//   err_clr      in   synchronous clear of sticky seg_error
//   bcd0..bcd3   out  [3:0] decoded code per digit (4'hF = none/illegal)
//   valid        out  full frame decoded and no timeout since
//   frame_done   out  one-cycle pulse when all four digits were committed
//   seg_error    out  sticky: an undecodable pattern was committed
//   scan_timeout out  no commit for TIMEOUT_CYCLES cycles
// -----------------------------------------------------------------------------
module seven_segment_scan_decoder #(
    parameter int unsigned STABLE_CYCLES  = 1,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] digit_in,
    input  logic [6:0] display_in,
    input  logic       err_clr,
    output logic [3:0] bcd0,
    output logic [3:0] bcd1,
    output logic [3:0] bcd2,
    output logic [3:0] bcd3,
    output logic       valid,
    output logic       frame_done,
    output logic       seg_error,
    output logic       scan_timeout
);

    localparam int unsigned   TO_W       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0]    STABLE_MAX = 8'(STABLE_CYCLES);
    localparam logic [TO_W-1:0] TO_MAX   = TO_W'(TIMEOUT_CYCLES);

    function automatic logic strobe_legal(input logic [3:0] d);
        return (d == 4'b1110) || (d == 4'b1101) || (d == 4'b1011) || (d == 4'b0111);
    endfunction

    function automatic logic [1:0] strobe_index(input logic [3:0] d);
        case (d)
            4'b1101: return 2'd1;
            4'b1011: return 2'd2;
            4'b0111: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    // Segment bits are active-low, so a '0' is a lit segment.
    function automatic logic [3:0] seg_decode(input logic [6:0] s);
        case (s)
            7'b0000001: return 4'd0;
            7'b1001111: return 4'd1;
            7'b0010010: return 4'd2;
            7'b0000110: return 4'd3;
            7'b1001100: return 4'd4;
            7'b0100100: return 4'd5;
            7'b0100000: return 4'd6;
            7'b0001111: return 4'd7;
            7'b0000000: return 4'd8;
            7'b0000100: return 4'd9;
            7'b1111110: return 4'd10;
            default:    return 4'hF;
        endcase
    endfunction

    // Registered state
    logic [3:0]       dig_q;
    logic [6:0]       seg_q;
    logic [7:0]       stab_q,   stab_d;
    logic             reach_q,  reach_d;
    logic [3:0]       seen_q,   seen_d;
    logic [TO_W-1:0]  to_q,     to_d;
    logic [3:0][3:0]  bcd_q,    bcd_d;
    logic             valid_q,  valid_d;
    logic             done_q,   done_d;
    logic             err_q,    err_d;
    logic             tmo_q,    tmo_d;

    // Combinational helpers
    logic       in_legal;
    logic       same_pair;
    logic       commit;
    logic [1:0] commit_idx;
    logic [3:0] commit_code;
    logic [3:0] seen_set;

    // NOTE: every signal driven here gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        in_legal  = strobe_legal(digit_in);
        same_pair = ({digit_in, display_in} == {dig_q, seg_q});

        // Dwell counter: counts identical legal samples, restarts on change.
        stab_d = 8'd0;
        if (in_legal && same_pair) begin
            stab_d = (stab_q == STABLE_MAX) ? stab_q : stab_q + 8'd1;
        end else if (in_legal) begin
            stab_d = 8'd1;
        end

        // Flag the single edge on which the dwell first becomes long enough.
        // A saturated hold does not re-trigger. The commit itself happens one
        // edge later from the sample register, so the outputs update
        // STABLE_CYCLES edges after the first sample.
        reach_d = in_legal && (stab_d == STABLE_MAX) &&
                  !(same_pair && (stab_q == STABLE_MAX));

        commit      = reach_q;
        commit_idx  = strobe_index(dig_q);
        commit_code = seg_decode(seg_q);
        seen_set    = seen_q | (4'b0001 << commit_idx);

        bcd_d   = bcd_q;
        seen_d  = seen_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        to_d    = to_q;
        tmo_d   = tmo_q;

        if (commit) begin
            bcd_d[commit_idx] = commit_code;
            to_d  = '0;
            tmo_d = 1'b0;
            if (seen_set == 4'b1111) begin
                done_d  = 1'b1;
                valid_d = 1'b1;
                seen_d  = 4'b0000;
            end else begin
                seen_d = seen_set;
            end
        end else if (to_q != TO_MAX) begin
            to_d = to_q + 1'b1;
            if (to_d == TO_MAX) begin
                tmo_d   = 1'b1;
                valid_d = 1'b0;
                seen_d  = 4'b0000;
            end
        end

        // Setting has priority over the clear.
        err_d = err_q;
        if (commit && (commit_code == 4'hF)) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dig_q   <= 4'b1111;
            seg_q   <= 7'b1111111;
            stab_q  <= 8'd0;
            reach_q <= 1'b0;
            seen_q  <= 4'b0000;
            to_q    <= '0;
            bcd_q   <= {4{4'hF}};
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            dig_q   <= digit_in;
            seg_q   <= display_in;
            stab_q  <= stab_d;
            reach_q <= reach_d;
            seen_q  <= seen_d;
            to_q    <= to_d;
            bcd_q   <= bcd_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
        end
    end

    assign bcd0         = bcd_q[0];
    assign bcd1         = bcd_q[1];
    assign bcd2         = bcd_q[2];
    assign bcd3         = bcd_q[3];
    assign valid        = valid_q;
    assign frame_done   = done_q;
    assign seg_error    = err_q;
    assign scan_timeout = tmo_q;

endmodule

// File: tb/tb_seven_segment_scan_decoder.sv
// -----------------------------------------------------------------------------
// tb_seven_segment_scan_decoder
//
// Instance a: STABLE_CYCLES=1, TIMEOUT_CYCLES=16. It runs a vector table for
// scanning, dash, illegal pattern and err_clr. Hand sequences cover timeout
// and reset.
// Instance b: STABLE_CYCLES=3, TIMEOUT_CYCLES=16. It covers dwell
// qualification.
// -----------------------------------------------------------------------------
module tb_seven_segment_scan_decoder;

    localparam logic [3:0] D0 = 4'b1110, D1 = 4'b1101, D2 = 4'b1011, D3 = 4'b0111;
    localparam logic [3:0] BL = 4'b1111, DZ = 4'b0000;
    localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010;
    localparam logic [6:0] S3 = 7'b0000110, S4 = 7'b1001100, S5 = 7'b0100100;
    localparam logic [6:0] S6 = 7'b0100000, S7 = 7'b0001111, S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0000100, SD = 7'b1111110, SX = 7'b1111000;
    localparam logic [6:0] SB = 7'b1111111;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] a_dig, b_dig;
    logic [6:0] a_seg, b_seg;
    logic       a_clr;
    logic [3:0] a_bcd0, a_bcd1, a_bcd2, a_bcd3;
    logic       a_valid, a_done, a_err, a_tmo;
    logic [3:0] b_bcd0, b_bcd1, b_bcd2, b_bcd3;
    logic       b_valid, b_done, b_err, b_tmo;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seven_segment_scan_decoder #(.STABLE_CYCLES(1), .TIMEOUT_CYCLES(16)) dut_a (
        .clk(clk), .reset(reset), .digit_in(a_dig), .display_in(a_seg),
        .err_clr(a_clr), .bcd0(a_bcd0), .bcd1(a_bcd1), .bcd2(a_bcd2),
        .bcd3(a_bcd3), .valid(a_valid), .frame_done(a_done),
        .seg_error(a_err), .scan_timeout(a_tmo)
    );

    seven_segment_scan_decoder #(.STABLE_CYCLES(3), .TIMEOUT_CYCLES(16)) dut_b (
        .clk(clk), .reset(reset), .digit_in(b_dig), .display_in(b_seg),
        .err_clr(1'b0), .bcd0(b_bcd0), .bcd1(b_bcd1), .bcd2(b_bcd2),
        .bcd3(b_bcd3), .valid(b_valid), .frame_done(b_done),
        .seg_error(b_err), .scan_timeout(b_tmo)
    );

    typedef struct {
        logic [3:0]  dig;
        logic [6:0]  seg;
        logic        clr;
        logic [15:0] bcd;   // expected {bcd3,bcd2,bcd1,bcd0} after the edge
        logic        done;
        logic        vld;
        logic        err;
    } vec_t;

    vec_t tbl [28];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive a pair at a falling edge, then wait through one rising edge.
    task automatic step_a(input logic [3:0] d, input logic [6:0] s, input logic c);
        a_dig = d;
        a_seg = s;
        a_clr = c;
        @(negedge clk);
    endtask

    task automatic step_b(input logic [3:0] d, input logic [6:0] s);
        b_dig = d;
        b_seg = s;
        @(negedge clk);
    endtask

    function automatic logic [15:0] a_bcd();
        return {a_bcd3, a_bcd2, a_bcd1, a_bcd0};
    endfunction

    initial begin
        logic done_seen;

        // Scan d0..d3 with {3,2,1,0}={4,0,9,7}. Then dash in order 3,0,2,1.
        // Then an illegal pattern, err_clr handling, and a non-strobe glitch.
        tbl[0]  = '{D0, S7, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{D1, S9, 1'b0, 16'hFFF7, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{D2, S0, 1'b0, 16'hFF97, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{D3, S4, 1'b0, 16'hF097, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{D0, S7, 1'b0, 16'h4097, 1'b1, 1'b1, 1'b0};
        tbl[5]  = '{D1, S9, 1'b0, 16'h4097, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{D2, S0, 1'b0, 16'h4097, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{D3, S4, 1'b0, 16'h4097, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{D0, S7, 1'b0, 16'h4097, 1'b1, 1'b1, 1'b0};
        tbl[9]  = '{D3, SD, 1'b0, 16'h4097, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{D0, SD, 1'b0, 16'hA097, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{D2, SD, 1'b0, 16'hA09A, 1'b0, 1'b1, 1'b0};
        tbl[12] = '{D1, SD, 1'b0, 16'hAA9A, 1'b0, 1'b1, 1'b0};
        tbl[13] = '{BL, SB, 1'b0, 16'hAAAA, 1'b1, 1'b1, 1'b0};
        tbl[14] = '{BL, SB, 1'b0, 16'hAAAA, 1'b0, 1'b1, 1'b0};
        tbl[15] = '{D2, SX, 1'b0, 16'hAAAA, 1'b0, 1'b1, 1'b0};
        tbl[16] = '{BL, SB, 1'b0, 16'hAFAA, 1'b0, 1'b1, 1'b1};
        tbl[17] = '{D0, S8, 1'b0, 16'hAFAA, 1'b0, 1'b1, 1'b1};
        tbl[18] = '{D1, S8, 1'b0, 16'hAFA8, 1'b0, 1'b1, 1'b1};
        tbl[19] = '{D2, S8, 1'b0, 16'hAF88, 1'b0, 1'b1, 1'b1};
        tbl[20] = '{D3, S8, 1'b0, 16'hA888, 1'b0, 1'b1, 1'b1};
        tbl[21] = '{BL, SB, 1'b0, 16'h8888, 1'b1, 1'b1, 1'b1};
        tbl[22] = '{BL, SB, 1'b1, 16'h8888, 1'b0, 1'b1, 1'b0};
        tbl[23] = '{D1, SX, 1'b0, 16'h8888, 1'b0, 1'b1, 1'b0};
        tbl[24] = '{BL, SB, 1'b1, 16'h88F8, 1'b0, 1'b1, 1'b1};
        tbl[25] = '{BL, SB, 1'b1, 16'h88F8, 1'b0, 1'b1, 1'b0};
        tbl[26] = '{4'b0101, S0, 1'b0, 16'h88F8, 1'b0, 1'b1, 1'b0};
        tbl[27] = '{BL, SB, 1'b0, 16'h88F8, 1'b0, 1'b1, 1'b0};

        reset = 1'b1;
        a_dig = BL; a_seg = SB; a_clr = 1'b0;
        b_dig = BL; b_seg = SB;
        repeat (2) @(negedge clk);

        check("reset bcd", a_bcd(), 16'hFFFF);
        check("reset flags", {12'd0, a_valid, a_done, a_err, a_tmo}, 16'h0);
        reset = 1'b0;

        // ---- Dwell qualification, STABLE_CYCLES=3 ----
        step_b(D1, S2);
        step_b(D1, S2);
        step_b(BL, SB);                 // broken after two samples
        step_b(BL, SB);
        check("b short dwell bcd1", {12'd0, b_bcd1}, 16'hF);
        step_b(D1, S2);                 // first sample (E0)
        step_b(D1, S2);
        step_b(D1, S2);
        check("b dwell E0+2 bcd1", {12'd0, b_bcd1}, 16'hF);
        step_b(D1, S2);                 // E0+3: committed
        check("b dwell E0+3 bcd1", {12'd0, b_bcd1}, 16'h2);
        step_b(D1, S2);
        check("b held bcd1", {12'd0, b_bcd1}, 16'h2);
        check("b held err", {15'd0, b_err}, 16'h0);
        step_b(BL, SB);

        // ---- Table, STABLE_CYCLES=1 ----
        for (int i = 0; i < 28; i++) begin
            step_a(tbl[i].dig, tbl[i].seg, tbl[i].clr);
            check($sformatf("vec%0d bcd", i), a_bcd(), tbl[i].bcd);
            check($sformatf("vec%0d frame_done", i), {15'd0, a_done}, {15'd0, tbl[i].done});
            check($sformatf("vec%0d valid", i), {15'd0, a_valid}, {15'd0, tbl[i].vld});
            check($sformatf("vec%0d seg_error", i), {15'd0, a_err}, {15'd0, tbl[i].err});
        end

        // ---- Timeout: full frame, then 0000 / 1111 with no commits ----
        step_a(D0, S7, 1'b0);
        step_a(D1, S9, 1'b0);
        step_a(D2, S0, 1'b0);
        step_a(D3, S4, 1'b0);
        step_a(DZ, S8, 1'b0);           // last commit on this edge
        check("pre-timeout frame_done", {15'd0, a_done}, 16'h1);
        check("pre-timeout valid", {15'd0, a_valid}, 16'h1);
        for (int i = 0; i < 15; i++) begin
            if (i < 7) step_a(DZ, S8, 1'b0);
            else       step_a(BL, SB, 1'b0);
        end
        check("timeout at 15", {15'd0, a_tmo}, 16'h0);
        step_a(BL, SB, 1'b0);
        check("timeout at 16", {15'd0, a_tmo}, 16'h1);
        check("timeout valid", {15'd0, a_valid}, 16'h0);
        check("timeout bcd kept", a_bcd(), 16'h4097);
        step_a(BL, SB, 1'b0);
        step_a(BL, SB, 1'b0);
        check("timeout held", {15'd0, a_tmo}, 16'h1);

        // ---- Resume scanning ----
        step_a(D0, S3, 1'b0);
        check("resume no commit yet", {15'd0, a_tmo}, 16'h1);
        step_a(D1, S5, 1'b0);
        check("resume first commit tmo", {15'd0, a_tmo}, 16'h0);
        check("resume first commit bcd", a_bcd(), 16'h4093);
        check("resume first commit valid", {15'd0, a_valid}, 16'h0);
        step_a(D2, S6, 1'b0);
        step_a(D3, S1, 1'b0);
        check("resume 3 commits valid", {15'd0, a_valid}, 16'h0);
        step_a(BL, SB, 1'b0);
        check("resume frame bcd", a_bcd(), 16'h1653);
        check("resume frame_done", {15'd0, a_done}, 16'h1);
        check("resume valid", {15'd0, a_valid}, 16'h1);

        // ---- Reset mid-frame ----
        step_a(D0, S2, 1'b0);
        step_a(D1, S8, 1'b0);
        step_a(D2, S9, 1'b0);
        check("pre-reset bcd", a_bcd(), 16'h1682);
        reset = 1'b1;
        a_dig = BL; a_seg = SB;
        #1;
        check("async reset bcd", a_bcd(), 16'hFFFF);
        check("async reset flags", {12'd0, a_valid, a_done, a_err, a_tmo}, 16'h0);
        @(negedge clk);
        reset = 1'b0;
        done_seen = 1'b0;
        step_a(D2, S5, 1'b0);
        done_seen = done_seen | a_done;
        step_a(D3, S6, 1'b0);
        done_seen = done_seen | a_done;
        step_a(BL, SB, 1'b0);
        done_seen = done_seen | a_done;
        step_a(BL, SB, 1'b0);
        done_seen = done_seen | a_done;
        check("post-reset partial bcd", a_bcd(), 16'h65FF);
        check("post-reset no frame_done", {15'd0, done_seen}, 16'h0);
        check("post-reset valid", {15'd0, a_valid}, 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seven_segment_scan_decoder.md
Name: seven_segment_scan_decoder

Overview:
- Receive-side counterpart of the 4-digit multiplexed seven-segment driver.
- Watches the scanned digit strobes (active-low, one-hot) and segment lines (active-low, bit6..0 = a..g), decodes each digit's pattern back to a 4-bit code, and holds all four codes.
- Used as an in-fabric display monitor and self-check: it reconstructs BCD0..BCD3, signals complete frames, and flags illegal patterns and stalled scanning.

Parameters:
- STABLE_CYCLES, 1, consecutive identical samples of a (strobe, segment) pair required before commit; legal range 1..255.
- TIMEOUT_CYCLES, 1024, number of cycles without a commit before scan_timeout asserts; legal range ≥ 8.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- digit_in  input  4  scanned digit strobes, active-low; bit k low selects digit k
- display_in  input  7  scanned segments, active-low, {a,b,c,d,e,f,g}
- err_clr  input  1  synchronous clear of sticky seg_error
- bcd0  output  4  decoded code of digit 0 (rightmost)
- bcd1  output  4  decoded code of digit 1
- bcd2  output  4  decoded code of digit 2
- bcd3  output  4  decoded code of digit 3
- valid  output  1  a complete frame has been decoded and scanning has not timed out since
- frame_done  output  1  one-cycle pulse when all four digits have been committed
- seg_error  output  1  sticky: an undecodable segment pattern was committed
- scan_timeout  output  1  no commit for TIMEOUT_CYCLES cycles

Behaviour:
- Reset (async, active-high) values:
  - bcd0..bcd3 = 4'hF; valid, frame_done, seg_error, scan_timeout = 0.
  - Sample register = {4'b1111, 7'b1111111}; stability counter = 0; seen[3:0] = 0; timeout counter = 0.
- Sampling: {digit_in, display_in} is registered every edge.
- Strobe qualification:
  - Legal strobes: 1110, 1101, 1011, 0111, mapping to digits 0..3.
  - Any other value, including 1111 (blank) and 0000 (the driver's reset value), is a non-strobe. It never commits and resets the stability counter to 0.
- Stability counter:
  - If the incoming pair equals the sampled pair and the strobe is legal, the counter increments, saturating at STABLE_CYCLES.
  - Otherwise the counter loads 1 if the strobe is legal, else 0.
- Commit rule: exactly one commit per dwell, on the edge where the counter reaches STABLE_CYCLES. A pair held at the pins before edge E0 gives registered outputs updated after edge E0+STABLE_CYCLES.
- Decode table (segments → code):
  - 0000001→0, 1001111→1, 0010010→2, 0000110→3, 1001100→4
  - 0100100→5, 0100000→6, 0001111→7, 0000000→8, 0000100→9
  - 1111110→10 (dash)
  - Any other pattern → 4'hF, and seg_error is set.
- On commit to digit k: bcdk updates and seen[k] is set. Re-committing an already-seen digit overwrites bcdk and has no other effect.
- Frame completion: when the commit makes seen == 4'b1111:
  - frame_done pulses for one cycle, on the edge after that commit.
  - valid is set to 1.
  - seen clears to 0.
  - Scan order is irrelevant.
- seg_error:
  - Set on any invalid-pattern commit; cleared only by reset or err_clr.
  - If err_clr and an invalid commit occur on the same edge, set wins.
- Timeout counter:
  - Counts cycles since the last commit and saturates at TIMEOUT_CYCLES.
  - On reaching TIMEOUT_CYCLES: scan_timeout = 1, valid = 0, seen cleared.
  - The next commit clears scan_timeout and the counter.
  - Commit and terminal count on the same edge: the commit wins, and scan_timeout stays 0.
- bcd outputs hold their last committed value through timeouts, non-strobes and glitches.
- Reset mid-dwell or mid-frame: everything returns to reset values immediately. A partial frame is discarded, and the next frame needs all four digits again.

Test Plan:
- Driver scan, STABLE_CYCLES=1, digits {3,2,1,0} = {4,0,9,7} rotated one per cycle (0,1,2,3) → bcd3..0 = 4,0,9,7; frame_done pulses once per 4 cycles, the first one after the 4th strobe commits; valid = 1.
- STABLE_CYCLES=3, digit 1 shows 2 (0010010) for 2 cycles then switches → no commit, bcd1 stays 4'hF. Hold 3 cycles → bcd1 = 2 exactly 3 edges after the first sample.
- Digit 2 shows 1111000 → bcd2 = 4'hF, seg_error = 1 and stays 1 through later valid frames; err_clr pulse → 0. err_clr together with another invalid commit → stays 1.
- Inputs held at digit_in = 0000, then 1111, for TIMEOUT_CYCLES (set to 16) after a valid frame → no commits; scan_timeout = 1 at cycle 16; valid = 0; bcd values retained. Resuming the scan → scan_timeout clears on the first commit, valid returns at the next full frame.
- Dash 1111110 on all digits → all bcd = 10 (4'hA), seg_error = 0. Digit order 3,0,2,1 → frame_done still pulses after the 4th distinct digit.
- Reset asserted after 2 of 4 digits committed → all outputs at reset values asynchronously; the two remaining digits alone do not produce frame_done.
